uart_tx_cfg: RTL and testbench
==============================

// Module: uart_tx_cfg
// PURPOSE
//  Parametrised UART transmitter with a built-in transmit FIFO.
//  - Supports 5-9 data bits, none/odd/even parity and 1 or 2 stop bits.
//  - Upstream logic pushes words on a valid/ready handshake. Frames go out LSB first, back-to-back, with no idle gap.
//  - Sits between the processor/bus side and the board TX pin. Next-generation transmitter for all UART links.
// PARAMETERS
//  CLKS_PER_BIT  10416  clk cycles per bit period; legal range >= 2
//  DATA_BITS     8      data bits per frame; legal range 5..9
//  PARITY        0      0 = none, 1 = odd, 2 = even (encodings from uart_pkg)
//  STOP_BITS     1      1 or 2
//  FIFO_DEPTH    4      TX FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1                     system clock, rising edge
//  rst         in   1                     reset, asynchronous, active-high
//  s_data      in   DATA_BITS             word to transmit
//  s_valid     in   1                     s_data valid
//  s_ready     out  1                     FIFO can accept; equals !full, combinational from count
//  tx          out  1                     serial line; idles high
//  busy        out  1                     high from start bit through last stop bit
//  done        out  1                     1-cycle pulse at the end of each frame's final stop bit
//  fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Reset values: tx=1, busy=0, done=0, fifo_count=0, s_ready=1, FSM=IDLE, baud counter=0.
//    Reset asserted mid-frame forces tx=1 immediately, flushes the FIFO and suppresses done.
//  - Push: a word is written on a rising edge where s_valid && s_ready. s_data is captured at that edge.
//    There is no push while full. A same-cycle pop does not free space for a push in that cycle.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE or START.
//    - IDLE: if the FIFO is not empty, pop into the shift register, compute parity, drive tx<=0, go to START.
//      Latency: word accepted at edge E into an empty FIFO while IDLE -> tx low after edge E+1.
//    - Every bit (start, data, parity, stop) is held exactly CLKS_PER_BIT cycles.
//      The baud counter restarts at 0 on every pop, so the first bit is never short.
//    - DATA: shift DATA_BITS bits, LSB first.
//    - PARITY (only when PARITY != 0): odd -> total ones across data+parity is odd; even -> that total is even.
//    - STOP: tx=1 for STOP_BITS bit periods. At the final cycle of the last stop bit, pulse done.
//      If the FIFO is non-empty, pop and enter START on the next edge (no idle gap); otherwise go to IDLE.
//  - Frame length = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
//  - busy=1 in every state except IDLE.
//  - FIFO: circular buffer. Read/write pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
//  - Illegal parameter values stop elaboration via a generate-time $error.
//  - Any unreachable state encoding returns to IDLE with tx=1.
// STRUCTURE
//  - uart_pkg holds:
//    - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN
//    - the FSM state localparams
//    - a clog2 helper function
//  - Sub-module uart_baud_gen(clk, rst, restart, tick) is the CLKS_PER_BIT counter.
//    It is shared with the future uart_rx_cfg.
//  - FIFO is inline (pointer/count logic). The FSM, shift register and parity logic live in the top module.
// TESTING (CLKS_PER_BIT=4 in sim)
//  1. 8N1, push 0xA5 once -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clk.
//     done pulses 40 clk after tx falls; busy low the next cycle.
//  2. PARITY=2, push 0x07 -> parity bit 1. PARITY=1, push 0x07 -> parity bit 0.
//     Frame length 44 clk in both cases.
//  3. STOP_BITS=2, DATA_BITS=5, push 0x1F -> tx = 0,1,1,1,1,1,1,1; frame length 32 clk.
//  4. FIFO_DEPTH=4, hold s_valid with 6 words 0x01..0x06:
//     - word 1 pops at once; words 2-5 fill the FIFO and s_ready goes low.
//     - word 6 is accepted the cycle after word 2 pops.
//     - all 6 frames are contiguous with no idle cycles between them.
//  5. Assert rst during the 3rd data bit of 0x55 -> tx=1, fifo_count=0 and busy=0 immediately, no done pulse.
//     After release, push 0x3C -> clean frame.
//  6. Push while full with a same-cycle pop -> write rejected. fifo_count ends at FIFO_DEPTH-1 and that word is not lost upstream.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter/receiver family.
// Contents:
//   PAR_NONE/PAR_ODD/PAR_EVEN - parity selection encodings for the PARITY parameter
//   state_t + ST_* constants  - transmit FSM state encodings
//   clog2()                   - ceiling log2 usable in parameter/port width expressions
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and asserts tick during the last cycle of each bit period.
// Ports:
//   clk     in  system clock, rising edge
//   rst     in  asynchronous active-high reset (counter -> 0)
//   restart in  forces the counter back to 0 on the next edge, starting a full bit period
//   tick    out high during the final cycle of the current bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  // Restart wins over wrap so a freshly started bit is always a full period long.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with an inline transmit FIFO.
// Frames: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits,
// sent back-to-back while the FIFO holds words.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset
//   s_data     in  word to transmit, captured when s_valid && s_ready at a rising edge
//   s_valid    in  s_data valid
//   s_ready    out FIFO not full
//   tx         out serial line, idles high
//   busy       out high from start bit through the last stop bit
//   done       out one-cycle pulse during the final cycle of each frame's last stop bit
//   fifo_count out words currently held in the FIFO
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       tx,
  output logic                       busy,
  output logic                       done,
  output logic [clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_cfg: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] rd_word;
  logic                 full, empty, push, pop, tick;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    return (PARITY == PAR_ODD) ? ~^word : ^word;
  endfunction

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(pop),
    .tick   (tick)
  );

  // FIFO bookkeeping. s_ready comes only from the registered count, so a pop in the
  // same cycle never opens room for a push while full.
  assign full       = (count_q == FULL_COUNT);
  assign empty      = (count_q == '0);
  assign s_ready    = !full;
  assign push       = s_valid && s_ready;
  assign rd_word    = mem_q[rd_ptr_q];
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data;
    end
  end

  // State register together with the shift/parity datapath it sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= 1'b1;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. tx_d is the level for the bit that begins at the next edge;
  // bit_cnt counts data bits in DATA and stop bits in STOP.
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        pop  = !empty;
      end
      ST_START: begin
        if (tick) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            pop     = !empty;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
    // A pop loads the next word and launches its start bit; the baud timer restarts with it.
    if (pop) begin
      shift_d   = rd_word;
      par_d     = parity_bit(rd_word);
      tx_d      = 1'b0;
      bit_cnt_d = '0;
      state_d   = ST_START;
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_STOP) && tick && (bit_cnt_q == LAST_STOP);
  end

  assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg with CLKS_PER_BIT=4.
// Four instances cover 8N1 (FIFO/reset cases), 8E1, 8O1 and 5N2.
module tb_uart_tx_cfg;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] sData0, sDataE, sDataO;
  logic [4:0] sData5;
  logic [3:0] sValid;
  logic [3:0] sReady, txV, busyV, doneV;
  logic [2:0] count0, countE, countO, count5;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int doneCount0 = 0;

  logic capBits [256];
  int   capDonePos [$];
  int   capBusyLow, capGlitch, capWait, capTimedOut;
  int   acc [6];
  logic readyAfterFill;
  logic [2:0] countAfterFill;

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u8n1 (
    .clk(clk), .rst(rst), .s_data(sData0), .s_valid(sValid[0]), .s_ready(sReady[0]),
    .tx(txV[0]), .busy(busyV[0]), .done(doneV[0]), .fifo_count(count0));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u8e1 (
    .clk(clk), .rst(rst), .s_data(sDataE), .s_valid(sValid[1]), .s_ready(sReady[1]),
    .tx(txV[1]), .busy(busyV[1]), .done(doneV[1]), .fifo_count(countE));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u8o1 (
    .clk(clk), .rst(rst), .s_data(sDataO), .s_valid(sValid[2]), .s_ready(sReady[2]),
    .tx(txV[2]), .busy(busyV[2]), .done(doneV[2]), .fifo_count(countO));

  uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u5n2 (
    .clk(clk), .rst(rst), .s_data(sData5), .s_valid(sValid[3]), .s_ready(sReady[3]),
    .tx(txV[3]), .busy(busyV[3]), .done(doneV[3]), .fifo_count(count5));

  // Free-running cycle stamp and a running tally of done pulses on the 8N1 instance.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (doneV[0] === 1'b1) doneCount0 <= doneCount0 + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one word on instance sel and return #1 after the edge that accepts it.
  task automatic applyStimulus(input int sel, input logic [8:0] word);
    int waited;
    @(negedge clk);
    case (sel)
      0: sData0 = word[7:0];
      1: sDataE = word[7:0];
      2: sDataO = word[7:0];
      default: sData5 = word[4:0];
    endcase
    sValid[sel] = 1'b1;
    waited = 0;
    while (!sReady[sel] && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!sReady[sel]) begin
      checkOutput("pushTimeout", waited, 0);
      sValid[sel] = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      sValid[sel] = 1'b0;
    end
  endtask

  // Wait for the start bit, then sample tx/done/busy on every falling edge for nbits bit periods.
  task automatic sampleStream(input int sel, input int nbits);
    capDonePos.delete();
    capBusyLow  = 0;
    capGlitch   = 0;
    capTimedOut = 0;
    capWait     = 0;
    while (capWait < 300) begin
      @(negedge clk);
      capWait++;
      if (txV[sel] === 1'b0) break;
    end
    if (txV[sel] !== 1'b0) begin
      capTimedOut = 1;
      return;
    end
    for (int k = 0; k < nbits * CPB; k++) begin
      if (k > 0) @(negedge clk);
      if (k % CPB == 0) capBits[k / CPB] = txV[sel];
      else if (txV[sel] !== capBits[k / CPB]) capGlitch++;
      if (doneV[sel] === 1'b1) capDonePos.push_back(k);
      if (busyV[sel] !== 1'b1) capBusyLow++;
    end
  endtask

  function automatic logic [15:0] frameBits(input int base, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = capBits[base + i];
    return r;
  endfunction

  task automatic checkSingleFrame(input string tag, input int sel, input int nbits, input logic [15:0] expBits);
    checkOutput({tag, ".timeout"}, capTimedOut, 0);
    checkOutput({tag, ".latency"}, capWait, 2);
    checkOutput({tag, ".bits"}, frameBits(0, nbits), expBits);
    checkOutput({tag, ".glitch"}, capGlitch, 0);
    checkOutput({tag, ".doneCount"}, capDonePos.size(), 1);
    checkOutput({tag, ".donePos"}, (capDonePos.size() > 0) ? capDonePos[0] : -1, nbits * CPB - 1);
    checkOutput({tag, ".busyLow"}, capBusyLow, 0);
    @(negedge clk);
    checkOutput({tag, ".busyAfter"}, busyV[sel], 0);
    checkOutput({tag, ".doneAfter"}, doneV[sel], 0);
  endtask

  initial begin
    int waited;
    int found;
    int doneBase;
    int lowSamples;

    rst    = 1'b1;
    sValid = '0;
    sData0 = '0;
    sDataE = '0;
    sDataO = '0;
    sData5 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.tx", txV, 4'hF);
    checkOutput("rst.busy", busyV, 4'h0);
    checkOutput("rst.done", doneV, 4'h0);
    checkOutput("rst.ready", sReady, 4'hF);
    checkOutput("rst.count", count0, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle.tx", txV, 4'hF);
    checkOutput("idle.busy", busyV, 4'h0);

    // 8N1, 0xA5: frame {stop, A5, start} = 0x34A
    applyStimulus(0, 9'h0A5);
    sampleStream(0, 10);
    checkSingleFrame("a5", 0, 10, 16'h034A);

    // 8E1, 0x07: three ones -> parity 1 -> 0x60E
    applyStimulus(1, 9'h007);
    sampleStream(1, 11);
    checkSingleFrame("even07", 1, 11, 16'h060E);

    // 8O1, 0x07: parity 0 -> 0x40E
    applyStimulus(2, 9'h007);
    sampleStream(2, 11);
    checkSingleFrame("odd07", 2, 11, 16'h040E);

    // 5N2, 0x1F: start 0, five ones, two stop -> 0xFE, 32 clk
    applyStimulus(3, 9'h01F);
    sampleStream(3, 8);
    checkSingleFrame("n2_1f", 3, 8, 16'h00FE);

    // Six words with s_valid held: contiguous frames, word 6 accepted 42 edges after word 1
    fork
      begin
        for (int w = 0; w < 6; w++) begin
          @(negedge clk);
          if (w == 5) begin
            readyAfterFill = sReady[0];
            countAfterFill = count0;
          end
          sData0    = 8'(w + 1);
          sValid[0] = 1'b1;
          waited = 0;
          while (!sReady[0] && waited < 200) begin
            @(negedge clk);
            waited++;
          end
          @(posedge clk);
          #1;
          acc[w] = cyc;
        end
        sValid[0] = 1'b0;
      end
      sampleStream(0, 60);
    join
    checkOutput("burst.fullReady", readyAfterFill, 0);
    checkOutput("burst.fullCount", countAfterFill, 4);
    for (int i = 1; i < 5; i++) checkOutput("burst.accGap", acc[i] - acc[0], i);
    checkOutput("burst.acc6", acc[5] - acc[0], 42);
    checkOutput("burst.timeout", capTimedOut, 0);
    checkOutput("burst.latency", capWait, 3);
    checkOutput("burst.glitch", capGlitch, 0);
    checkOutput("burst.busyLow", capBusyLow, 0);
    checkOutput("burst.doneCount", capDonePos.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("burst.frame", frameBits(10 * i, 10), 16'h0200 | 16'((i + 1) << 1));
      if (capDonePos.size() > i) checkOutput("burst.donePos", capDonePos[i], 39 + 40 * i);
    end
    @(negedge clk);
    checkOutput("burst.busyAfter", busyV[0], 0);

    // Push while full with a same-cycle pop: rejected, accepted one edge later
    doneBase = doneCount0;
    applyStimulus(0, 9'h0A1);
    applyStimulus(0, 9'h0B2);
    applyStimulus(0, 9'h0C3);
    applyStimulus(0, 9'h0D4);
    applyStimulus(0, 9'h0E5);
    @(negedge clk);
    checkOutput("full.count", count0, 4);
    checkOutput("full.ready", sReady[0], 0);
    sData0    = 8'hF6;
    sValid[0] = 1'b1;
    waited = 0;
    while (!sReady[0] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("full.readyReturn", sReady[0], 1);
    checkOutput("full.countAtPop", count0, 3);
    @(posedge clk);
    #1;
    sValid[0] = 1'b0;
    @(negedge clk);
    checkOutput("full.countAfterPush", count0, 4);
    waited = 0;
    while (busyV[0] && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("full.drained", busyV[0], 0);
    checkOutput("full.frames", doneCount0 - doneBase, 6);

    // Reset during the third data bit of 0x55 with two more words queued
    applyStimulus(0, 9'h055);
    found = 0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (txV[0] === 1'b0) begin
        found = 1;
        break;
      end
    end
    checkOutput("rstMid.start", found, 1);
    applyStimulus(0, 9'h011);
    applyStimulus(0, 9'h022);
    repeat (11) @(negedge clk);
    checkOutput("rstMid.countBefore", count0, 2);
    checkOutput("rstMid.busyBefore", busyV[0], 1);
    doneBase = doneCount0;
    rst = 1'b1;
    #1;
    checkOutput("rstMid.tx", txV[0], 1);
    checkOutput("rstMid.count", count0, 0);
    checkOutput("rstMid.busy", busyV[0], 0);
    checkOutput("rstMid.done", doneV[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lowSamples = 0;
    for (int w = 0; w < 60; w++) begin
      @(negedge clk);
      if (txV[0] !== 1'b1) lowSamples++;
    end
    checkOutput("rstMid.flushed", lowSamples, 0);
    checkOutput("rstMid.noDone", doneCount0 - doneBase, 0);

    // Clean frame after reset: 0x3C -> 0x278
    applyStimulus(0, 9'h03C);
    sampleStream(0, 10);
    checkSingleFrame("after3c", 0, 10, 16'h0278);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
